// File: rtl/balanca_pkg.sv
// Shared types and helpers for the scale display BCD path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package balanca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } estado_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Decimal digits needed for 2^bin_w - 1 (30103/100000 ~ log10(2)).
    function automatic int conv_digits(input int bin_w);
        return (bin_w * 30103) / 100000 + 1;
    endfunction

    function automatic logic [3:0] add3_digit(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_add3_estagio.sv
// Per-digit add-3 correction of the BCD accumulator ahead of each shift.
// Latency: combinational, zero cycles.
// Backpressure: none, pure logic.
module bcd_add3_estagio
    import balanca_pkg::*;
#(
    parameter int N_DIG = 5
) (
    input  logic [4*N_DIG-1:0] acc_in,
    output logic [4*N_DIG-1:0] acc_out
);

    for (genvar g = 0; g < N_DIG; g++) begin : g_digito
        assign acc_out[4*g +: 4] = add3_digit(acc_in[4*g +: 4]);
    end

endmodule

// File: rtl/conversor_bcd_ponto_fixo.sv
// Iterative binary to fixed-point BCD converter (shift-add-3), with saturation; CONVERSOR_BCD_ZERO_BLANK_EN blanks leading integer zeros.
// Latency: out_valid rises on the BIN_W-th edge after the acceptance edge (BIN_W+1 edges counting it).
// Backpressure: single result register held in DONE until out_ready; in_ready only in IDLE.
module conversor_bcd_ponto_fixo
    import balanca_pkg::*;
#(
    parameter int BIN_W    = 16,
    parameter int INT_DIG  = 2,
    parameter int FRAC_DIG = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*INT_DIG-1:0]  bcd_inteiro,
    output logic [4*FRAC_DIG-1:0] bcd_fracionario,
    output logic                  overflow
);

    localparam int CONV_DIG = conv_digits(BIN_W);
    localparam int OUT_DIG  = INT_DIG + FRAC_DIG;
    localparam int MAX_DIG  = (CONV_DIG > OUT_DIG) ? CONV_DIG : OUT_DIG;
    localparam int ACC_W    = 4 * CONV_DIG;
    localparam int CNT_W    = $clog2(BIN_W + 1);

    estado_t estado, estado_n;

    logic [BIN_W-1:0]      shreg;
    logic [BIN_W-1:0]      shreg_shift;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_corr;
    logic [ACC_W-1:0]      acc_shift;
    logic [CNT_W-1:0]      cnt;
    logic                  aceita;
    logic                  ultimo;
    logic [4*MAX_DIG-1:0]  acc_ext;
    logic                  ovf_calc;
    logic [4*INT_DIG-1:0]  int_calc;
    logic [4*FRAC_DIG-1:0] frac_calc;

    bcd_add3_estagio #(
        .N_DIG (CONV_DIG)
    ) u_add3 (
        .acc_in  (acc),
        .acc_out (acc_corr)
    );

    assign acc_shift   = {acc_corr[ACC_W-2:0], shreg[BIN_W-1]};
    assign shreg_shift = {shreg[BIN_W-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= estado_n;
        end
    end

    always_comb begin
        estado_n  = estado;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        aceita    = 1'b0;
        ultimo    = 1'b0;
        case (estado)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    aceita   = 1'b1;
                    estado_n = CONV;
                end
            end
            CONV: begin
                if (cnt == CNT_W'(1)) begin
                    ultimo   = 1'b1;
                    estado_n = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    estado_n = IDLE;
                end
            end
            default: begin
                estado_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (aceita) begin
            shreg <= bin_in;
            acc   <= '0;
            cnt   <= CNT_W'(BIN_W);
        end else if (estado == CONV) begin
            shreg <= shreg_shift;
            acc   <= acc_shift;
            cnt   <= cnt - CNT_W'(1);
        end
    end

    // Zero-extend so narrow accumulators still fill every output digit.
    always_comb begin
        acc_ext            = '0;
        acc_ext[ACC_W-1:0] = acc_shift;
    end

    if (MAX_DIG > OUT_DIG) begin : g_ovf
        assign ovf_calc = |acc_ext[4*MAX_DIG-1:4*OUT_DIG];
    end else begin : g_sem_ovf
        assign ovf_calc = 1'b0;
    end

`ifdef CONVERSOR_BCD_ZERO_BLANK_EN
    logic blank_ativo;
`endif

    always_comb begin
        int_calc  = acc_ext[4*OUT_DIG-1:4*FRAC_DIG];
        frac_calc = acc_ext[4*FRAC_DIG-1:0];
        if (ovf_calc) begin
            int_calc  = {INT_DIG{4'h9}};
            frac_calc = {FRAC_DIG{4'h9}};
        end
`ifdef CONVERSOR_BCD_ZERO_BLANK_EN
        // Units digit (index 0) is always shown, so the scan stops at 1.
        blank_ativo = !ovf_calc;
        for (int i = INT_DIG - 1; i >= 1; i--) begin
            if (blank_ativo && (int_calc[4*i +: 4] == 4'd0)) begin
                int_calc[4*i +: 4] = BCD_BLANK;
            end else begin
                blank_ativo = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_inteiro     <= '0;
            bcd_fracionario <= '0;
            overflow        <= 1'b0;
        end else if (ultimo) begin
            bcd_inteiro     <= int_calc;
            bcd_fracionario <= frac_calc;
            overflow        <= ovf_calc;
        end
    end

endmodule

// File: tb/tb_conversor_bcd_ponto_fixo.sv
// Directed bench for two converter configurations (16/2/2 and 8/3/1).
// Expected fields are hand-computed; blanked variants used when CONVERSOR_BCD_ZERO_BLANK_EN is defined.
module tb_conversor_bcd_ponto_fixo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Configuration A: BIN_W=16, INT_DIG=2, FRAC_DIG=2
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_ovf;
    logic [15:0] a_bin = '0;
    logic [7:0]  a_int, a_frac;

    // Configuration B: BIN_W=8, INT_DIG=3, FRAC_DIG=1
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_ovf;
    logic [7:0]  b_bin = '0;
    logic [11:0] b_int;
    logic [3:0]  b_frac;

    conversor_bcd_ponto_fixo #(.BIN_W(16), .INT_DIG(2), .FRAC_DIG(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .bin_in(a_bin),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .bcd_inteiro(a_int), .bcd_fracionario(a_frac), .overflow(a_ovf)
    );

    conversor_bcd_ponto_fixo #(.BIN_W(8), .INT_DIG(3), .FRAC_DIG(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .bin_in(b_bin),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .bcd_inteiro(b_int), .bcd_fracionario(b_frac), .overflow(b_ovf)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nome, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] bin;
        logic [7:0]  e_int;
        logic [7:0]  e_int_blank;
        logic [7:0]  e_frac;
        logic        e_ovf;
    } vec_a_t;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] e_int;
        logic [11:0] e_int_blank;
        logic [3:0]  e_frac;
    } vec_b_t;

    // Start a conversion on A; edges counts the acceptance edge as 1.
    task automatic start_a(input logic [15:0] v, output logic done, output int edges);
        @(negedge clk);
        a_bin = v;
        a_in_valid = 1'b1;
        chk("a_in_ready_before_accept", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        edges = 1;
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (a_out_valid) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            edges++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL a_timeout: out_valid never rose for bin %0d", v);
        end
    endtask

    task automatic start_b(input logic [7:0] v, output logic done, output int edges);
        @(negedge clk);
        b_bin = v;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        edges = 1;
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (b_out_valid) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            edges++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL b_timeout: out_valid never rose for bin %0d", v);
        end
    endtask

    task automatic release_a();
        @(negedge clk);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk("a_out_valid_after_hs", 32'(a_out_valid), 32'd0);
        chk("a_in_ready_after_hs", 32'(a_in_ready), 32'd1);
    endtask

    task automatic release_b();
        @(negedge clk);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk("b_out_valid_after_hs", 32'(b_out_valid), 32'd0);
    endtask

    initial begin
        vec_a_t va[10];
        vec_b_t vb[5];
        logic   done;
        int     edges;
        logic [7:0]  exp_ai;
        logic [11:0] exp_bi;

        va[0] = '{16'd1234,  8'h12, 8'h12, 8'h34, 1'b0};
        va[1] = '{16'd65535, 8'h99, 8'h99, 8'h99, 1'b1};
        va[2] = '{16'd9999,  8'h99, 8'h99, 8'h99, 1'b0};
        va[3] = '{16'd512,   8'h05, 8'hF5, 8'h12, 1'b0};
        va[4] = '{16'd0,     8'h00, 8'hF0, 8'h00, 1'b0};
        va[5] = '{16'd10000, 8'h99, 8'h99, 8'h99, 1'b1};
        va[6] = '{16'd100,   8'h01, 8'hF1, 8'h00, 1'b0};
        va[7] = '{16'd1000,  8'h10, 8'h10, 8'h00, 1'b0};
        va[8] = '{16'd99,    8'h00, 8'hF0, 8'h99, 1'b0};
        va[9] = '{16'd4321,  8'h43, 8'h43, 8'h21, 1'b0};

        vb[0] = '{8'd255, 12'h025, 12'hF25, 4'h5};
        vb[1] = '{8'd0,   12'h000, 12'hFF0, 4'h0};
        vb[2] = '{8'd99,  12'h009, 12'hFF9, 4'h9};
        vb[3] = '{8'd100, 12'h010, 12'hF10, 4'h0};
        vb[4] = '{8'd200, 12'h020, 12'hF20, 4'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_int", 32'(a_int), 32'h0);
        chk("rst_a_frac", 32'(a_frac), 32'h0);
        chk("rst_a_ovf", 32'(a_ovf), 32'd0);
        chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
        chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors, configuration A
        for (int i = 0; i < 10; i++) begin
`ifdef CONVERSOR_BCD_ZERO_BLANK_EN
            exp_ai = va[i].e_int_blank;
`else
            exp_ai = va[i].e_int;
`endif
            start_a(va[i].bin, done, edges);
            if (done) begin
                chk($sformatf("a_latency_%0d", va[i].bin), 32'(edges), 32'd17);
                chk($sformatf("a_int_%0d", va[i].bin), 32'(a_int), 32'(exp_ai));
                chk($sformatf("a_frac_%0d", va[i].bin), 32'(a_frac), 32'(va[i].e_frac));
                chk($sformatf("a_ovf_%0d", va[i].bin), 32'(a_ovf), 32'(va[i].e_ovf));
            end
            release_a();
        end

        // Table-driven vectors, configuration B
        for (int i = 0; i < 5; i++) begin
`ifdef CONVERSOR_BCD_ZERO_BLANK_EN
            exp_bi = vb[i].e_int_blank;
`else
            exp_bi = vb[i].e_int;
`endif
            start_b(vb[i].bin, done, edges);
            if (done) begin
                chk($sformatf("b_latency_%0d", vb[i].bin), 32'(edges), 32'd9);
                chk($sformatf("b_int_%0d", vb[i].bin), 32'(b_int), 32'(exp_bi));
                chk($sformatf("b_frac_%0d", vb[i].bin), 32'(b_frac), 32'(vb[i].e_frac));
                chk($sformatf("b_ovf_%0d", vb[i].bin), 32'(b_ovf), 32'd0);
            end
            release_b();
        end

        // Held result under backpressure; in_valid pulses with 42 are ignored
        start_a(16'd1234, done, edges);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a_bin = 16'd42;
            a_in_valid = (c % 2) == 0;
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(a_out_valid), 32'd1);
            chk("hold_in_ready", 32'(a_in_ready), 32'd0);
            chk("hold_int", 32'(a_int), 32'h12);
            chk("hold_frac", 32'(a_frac), 32'h34);
        end
        // Handshake edge with in_valid still high must not also accept
        @(negedge clk);
        a_in_valid = 1'b1;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        chk("hs_out_valid", 32'(a_out_valid), 32'd0);
        chk("hs_in_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(a_in_ready), 32'd1);
        chk("kept_int", 32'(a_int), 32'h12);
        chk("kept_frac", 32'(a_frac), 32'h34);
        chk("kept_ovf", 32'(a_ovf), 32'd0);

        // Reset in cycle 8 of CONV aborts at once
        @(negedge clk);
        a_bin = 16'd9999;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("pre_abort_in_ready", 32'(a_in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(a_out_valid), 32'd0);
        chk("abort_in_ready", 32'(a_in_ready), 32'd1);
        chk("abort_int", 32'(a_int), 32'h0);
        chk("abort_frac", 32'(a_frac), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start_a(16'd5, done, edges);
        if (done) begin
`ifdef CONVERSOR_BCD_ZERO_BLANK_EN
            chk("post_abort_int", 32'(a_int), 32'hF0);
`else
            chk("post_abort_int", 32'(a_int), 32'h00);
`endif
            chk("post_abort_frac", 32'(a_frac), 32'h05);
            chk("post_abort_latency", 32'(edges), 32'd17);
        end
        release_a();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
